// File: rtl/data_island_packet_scheduler.sv
// HDMI data-island slot scheduler: picks ACR, audio, AVI, audio InfoFrame
// or null per packet slot and acknowledges the chosen packet source.
module data_island_packet_scheduler #(
  parameter int unsigned SAMPLE_COUNT_MAX        = 8,
  parameter int unsigned SAMPLES_PER_PACKET      = 4,
  parameter bit          AUDIO_INFO_FRAME_ENABLE = 1'b1
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       packet_enable,
  input  logic       frame_start,
  input  logic       acr_request,
  input  logic       sample_valid,
  output logic [7:0] packet_type,
  output logic [3:0] sample_present,
  output logic [2:0] sample_take,
  output logic       acr_ack,
  output logic       avi_ack,
  output logic       audio_info_ack,
  output logic       sample_overflow
);

  localparam logic [3:0] CMAX = 4'(SAMPLE_COUNT_MAX);
  localparam logic [2:0] SPP  = 3'(SAMPLES_PER_PACKET);

  logic [3:0] count;
  logic       acr_pending;
  logic       avi_pending;
  logic       ainfo_pending;

  logic       sel_acr;
  logic       sel_aud;
  logic       sel_avi;
  logic       sel_ainfo;
  logic [2:0] n_avail;
  logic [2:0] take_n;
  logic [3:0] nxt_present;
  logic [7:0] nxt_type;
  logic [4:0] cnt_sum;
  logic       cnt_sat;

  // Decision uses only registered pending state, so same-cycle
  // requests wait for the following slot.
  always_comb begin
    sel_acr   = 1'b0;
    sel_aud   = 1'b0;
    sel_avi   = 1'b0;
    sel_ainfo = 1'b0;
    n_avail   = (count > {1'b0, SPP}) ? SPP : count[2:0];
    if (packet_enable) begin
      if (acr_pending)        sel_acr   = 1'b1;
      else if (count != 4'd0) sel_aud   = 1'b1;
      else if (avi_pending)   sel_avi   = 1'b1;
      else if (ainfo_pending) sel_ainfo = 1'b1;
    end
    take_n      = sel_aud ? n_avail : 3'd0;
    nxt_present = 4'((5'd1 << take_n) - 5'd1);
    nxt_type    = 8'h00;
    unique case (1'b1)
      sel_acr:   nxt_type = 8'h01;
      sel_aud:   nxt_type = 8'h02;
      sel_avi:   nxt_type = 8'h82;
      sel_ainfo: nxt_type = 8'h84;
      default:   nxt_type = 8'h00;
    endcase
  end

  assign cnt_sum = {1'b0, count} + 5'(sample_valid) - 5'(take_n);
  assign cnt_sat = (count == CMAX) && sample_valid && (take_n == 3'd0);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      count           <= 4'd0;
      acr_pending     <= 1'b0;
      avi_pending     <= 1'b0;
      ainfo_pending   <= 1'b0;
      packet_type     <= 8'h00;
      sample_present  <= 4'd0;
      sample_take     <= 3'd0;
      acr_ack         <= 1'b0;
      avi_ack         <= 1'b0;
      audio_info_ack  <= 1'b0;
      sample_overflow <= 1'b0;
    end else begin
      acr_ack        <= sel_acr;
      avi_ack        <= sel_avi;
      audio_info_ack <= sel_ainfo;
      sample_take    <= take_n;
      if (packet_enable) begin
        packet_type    <= nxt_type;
        sample_present <= nxt_present;
      end
      if (acr_request)  acr_pending <= 1'b1;
      else if (sel_acr) acr_pending <= 1'b0;
      if (frame_start)  avi_pending <= 1'b1;
      else if (sel_avi) avi_pending <= 1'b0;
      if (frame_start && AUDIO_INFO_FRAME_ENABLE) ainfo_pending <= 1'b1;
      else if (sel_ainfo)                         ainfo_pending <= 1'b0;
      if (cnt_sat) sample_overflow <= 1'b1;
      else         count           <= cnt_sum[3:0];
    end
  end

endmodule

// File: tb/tb_data_island_packet_scheduler.sv
// Scoreboard bench for data_island_packet_scheduler: directed slots,
// expected decisions queued by stimulus and checked by a monitor.
module tb_data_island_packet_scheduler;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic       packet_enable;
  logic       frame_start;
  logic       acr_request;
  logic       sample_valid;
  logic [7:0] packet_type;
  logic [3:0] sample_present;
  logic [2:0] sample_take;
  logic       acr_ack;
  logic       avi_ack;
  logic       audio_info_ack;
  logic       sample_overflow;

  typedef struct packed {
    logic [7:0] pt;
    logic [3:0] sp;
    logic [2:0] st;
    logic [2:0] ak;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic pe_q     = 1'b0;

  always #5 clk_pixel = ~clk_pixel;

  data_island_packet_scheduler dut (
    .clk_pixel      (clk_pixel),
    .reset_n        (reset_n),
    .packet_enable  (packet_enable),
    .frame_start    (frame_start),
    .acr_request    (acr_request),
    .sample_valid   (sample_valid),
    .packet_type    (packet_type),
    .sample_present (sample_present),
    .sample_take    (sample_take),
    .acr_ack        (acr_ack),
    .avi_ack        (avi_ack),
    .audio_info_ack (audio_info_ack),
    .sample_overflow(sample_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outputs are presented on the cycle after each packet_enable.
  always @(posedge clk_pixel) pe_q <= packet_enable;

  always @(negedge clk_pixel) begin
    if (reset_n) begin
      if (pe_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_slot", 32'd1, 32'd0);
        end else begin
          exp_t e;
          exp_t a;
          e = exp_q.pop_front();
          a = '{packet_type, sample_present, sample_take,
                {acr_ack, avi_ack, audio_info_ack}};
          chk("slot", 32'(a), 32'(e));
        end
      end else begin
        chk("idle_pulses",
            {28'd0, sample_take, acr_ack | avi_ack | audio_info_ack},
            32'd0);
      end
    end
  end

  task automatic drive(input logic pe, input logic fs,
                       input logic acr, input logic sv);
    packet_enable = pe;
    frame_start   = fs;
    acr_request   = acr;
    sample_valid  = sv;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic slot(input logic [7:0] pt, input logic [3:0] sp,
                      input logic [2:0] st, input logic [2:0] ak);
    exp_q.push_back('{pt, sp, st, ak});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n       = 1'b0;
    packet_enable = 1'b0;
    frame_start   = 1'b0;
    acr_request   = 1'b0;
    sample_valid  = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1;
    chk("reset_type", {24'd0, packet_type}, 32'h00);
    chk("reset_misc", {25'd0, sample_present, sample_take},
        32'd0);
    chk("reset_flags", {28'd0, acr_ack, avi_ack, audio_info_ack,
                        sample_overflow}, 32'd0);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    @(posedge clk_pixel);
    #1;

    // Idle slots
    for (int i = 0; i < 3; i++) slot(8'h00, 4'h0, 3'd0, 3'b000);

    // Frame start -> AVI then audio InfoFrame
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    slot(8'h82, 4'h0, 3'd0, 3'b010);
    slot(8'h84, 4'h0, 3'd0, 3'b001);
    slot(8'h00, 4'h0, 3'd0, 3'b000);

    // Six samples -> 4 + 2
    samples(6);
    slot(8'h02, 4'hf, 3'd4, 3'b000);
    slot(8'h02, 4'h3, 3'd2, 3'b000);
    slot(8'h00, 4'h0, 3'd0, 3'b000);

    // Priority ordering
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    slot(8'h01, 4'h0, 3'd0, 3'b100);
    slot(8'h02, 4'h1, 3'd1, 3'b000);
    slot(8'h82, 4'h0, 3'd0, 3'b010);
    slot(8'h84, 4'h0, 3'd0, 3'b001);
    chk("no_overflow_yet", {31'd0, sample_overflow}, 32'd0);

    // Saturation at 8
    samples(9);
    chk("overflow_set", {31'd0, sample_overflow}, 32'd1);
    slot(8'h02, 4'hf, 3'd4, 3'b000);
    slot(8'h02, 4'hf, 3'd4, 3'b000);
    slot(8'h00, 4'h0, 3'd0, 3'b000);
    chk("overflow_sticky", {31'd0, sample_overflow}, 32'd1);

    // Push coincident with a take of 3
    samples(3);
    exp_q.push_back('{8'h02, 4'h7, 3'd3, 3'b000});
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    slot(8'h02, 4'h1, 3'd1, 3'b000);
    slot(8'h00, 4'h0, 3'd0, 3'b000);

    // ACR arriving with packet_enable waits one slot
    exp_q.push_back('{8'h00, 4'h0, 3'd0, 3'b000});
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    slot(8'h01, 4'h0, 3'd0, 3'b100);
    slot(8'h00, 4'h0, 3'd0, 3'b000);

    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_island_packet_scheduler.md
Name: data_island_packet_scheduler

Overview:
- Per-slot scheduler for the HDMI data-island packet datapath.
- At each packet slot it picks one packet to send, in fixed priority: Audio Clock Regeneration, Audio Sample, AVI InfoFrame, Audio InfoFrame, Null.
- It drives the packet-type select for the header/subpacket mux and returns consume acknowledges to the packet sources.
- It sits between the TMDS period controller, which issues slot pulses, and the packet generators, which are selected by its output.

Parameters:
- SAMPLE_COUNT_MAX, 8: saturation limit of the pending-audio-sample counter (1..15).
- SAMPLES_PER_PACKET, 4: maximum samples carried per Audio Sample packet (1..4).
- AUDIO_INFO_FRAME_ENABLE, 1'b1: 0 = Audio InfoFrame is never scheduled.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- packet_enable  in  1  one-cycle pulse: a new packet slot begins.
- frame_start  in  1  one-cycle pulse at the start of each video frame.
- acr_request  in  1  one-cycle pulse: an ACR packet is due.
- sample_valid  in  1  one-cycle pulse: one audio sample has been pushed upstream.
- packet_type  out  8  selected HB0 type: 0x00 null, 0x01 ACR, 0x02 audio sample, 0x82 AVI, 0x84 audio InfoFrame.
- sample_present  out  4  Audio Sample packet sample_present bits, thermometer-coded from bit 0.
- sample_take  out  3  one-cycle count of samples consumed (0..4).
- acr_ack  out  1  one-cycle pulse: ACR scheduled.
- avi_ack  out  1  one-cycle pulse: AVI InfoFrame scheduled.
- audio_info_ack  out  1  one-cycle pulse: Audio InfoFrame scheduled.
- sample_overflow  out  1  sticky: a sample was dropped at saturation.

Behaviour:
- Reset (async assert, sync deassert use), all state cleared:
  - outputs: packet_type=0x00, sample_present=0, sample_take=0, all acks=0, sample_overflow=0.
  - internal: sample_count=0, acr_pending=0, avi_pending=0, ainfo_pending=0.
- Pending flags:
  - acr_request sets acr_pending.
  - frame_start sets avi_pending, and sets ainfo_pending if AUDIO_INFO_FRAME_ENABLE.
  - If a flag is already set, setting it again has no effect; requests coalesce.
- Decision:
  - Evaluated only in a cycle with packet_enable=1, using pending state from before that cycle (registered values).
  - A request or frame_start arriving in the same cycle as packet_enable is not eligible for that slot; it is served at the next slot.
- Priority at decision:
  1. acr_pending → 0x01; clear acr_pending; acr_ack=1.
  2. sample_count≥1 → 0x02; n=min(sample_count, SAMPLES_PER_PACKET); sample_present=(1<<n)-1; sample_take=n.
  3. avi_pending → 0x82; clear; avi_ack=1.
  4. ainfo_pending → 0x84; clear; audio_info_ack=1.
  5. Otherwise → 0x00 null; sample_present=0.
- Output timing:
  - packet_type and sample_present are registered. They update in the cycle after packet_enable (latency 1) and hold until the next decision.
  - Acks and sample_take are high for exactly that one cycle; otherwise 0.
- Sample counter:
  - Next value is count + sample_valid − n, where n is taken only on a decision cycle that selected audio.
  - A simultaneous push and take are both applied.
  - If count==SAMPLE_COUNT_MAX and sample_valid=1 with no take that cycle: count holds, sample_overflow sets, and only reset clears it.
  - The counter never underflows, since n≤count.
- Starvation: InfoFrames wait while ACR or samples are pending; a continuous audio stream can defer AVI indefinitely. This is accepted; slot rate exceeds sample rate in all supported modes.
- A frame_start while avi_pending is still set leaves one pending AVI (no queueing).
- packet_enable pulses closer than 2 cycles apart are illegal; the behaviour is undefined.
- Reset asserted mid-slot: outputs return to reset values immediately; the slot in progress carries null.

Test Plan:
- Reset, then 3 packet_enable pulses with no requests → packet_type=0x00 after each; all acks 0; sample_present=0.
- frame_start, then 2 slots → slot1 0x82 with avi_ack; slot2 0x84 with audio_info_ack; slot3 0x00.
- Six sample_valid pulses, then 2 slots → slot1 0x02, sample_present=4'b1111, sample_take=4; slot2 sample_present=4'b0011, sample_take=2; count=0.
- Same-cycle acr_request and frame_start with 1 pending sample, then 4 slots → sequence 0x01, 0x02 (present 4'b0001), 0x82, 0x84.
- Nine sample_valid pulses with no slots (SAMPLE_COUNT_MAX=8) → count=8, sample_overflow=1; two slots → take 4, take 4; overflow stays 1.
- sample_valid coincident with a decision taking 3 of 3 → next count=1; acr_request coincident with packet_enable → ACR not sent that slot; 0x01 appears at next slot.
